game_flow_ctrl: RTL

- Top-level round sequencer, directly downstream of the win/lose detector. Consumes its sticky game_lost/game_won flags and the player's start/pause buttons.
- Drives the title / play / pause / end-screen flow, the current level number, and a one-cycle round_rst pulse.
- round_rst re-initialises the invaders, player, bullets and the win/lose detector for each new round.

---
 rtl/game_flow_ctrl.sv | 140 ++++++++++++++
 1 files changed

// File: rtl/game_flow_ctrl.sv
// Round sequencer: title / play / pause / end-screen flow, level tracking and
// the one-cycle round_rst pulse that re-initialises all game entities.
module game_flow_ctrl #(
  parameter int END_SCREEN_CYCLES = 130_000_000,
  parameter int GUARD_CYCLES      = 4,
  parameter int MAX_LEVEL         = 9,
  parameter int LEVEL_W           = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               btn_start,
  input  logic               btn_pause,
  input  logic               game_lost,
  input  logic               game_won,
  output logic               round_rst,
  output logic               game_active,
  output logic               paused,
  output logic [1:0]         screen,
  output logic [LEVEL_W-1:0] level
);

  localparam int END_W   = $clog2(END_SCREEN_CYCLES + 1);
  localparam int GUARD_W = $clog2(GUARD_CYCLES + 1);

  localparam logic [END_W-1:0]   END_LOAD   = END_W'(END_SCREEN_CYCLES - 1);
  localparam logic [GUARD_W-1:0] GUARD_LOAD = GUARD_W'(GUARD_CYCLES);
  localparam logic [LEVEL_W-1:0] LEVEL_MIN  = LEVEL_W'(1);
  localparam logic [LEVEL_W-1:0] LEVEL_MAX  = LEVEL_W'(MAX_LEVEL);

  localparam logic [2:0] S_TITLE = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_PLAY  = 3'd2;
  localparam logic [2:0] S_PAUSE = 3'd3;
  localparam logic [2:0] S_WON   = 3'd4;
  localparam logic [2:0] S_LOST  = 3'd5;

  logic [2:0]         r_state;
  logic               r_start_q;
  logic               r_pause_q;
  logic [END_W-1:0]   r_end_cnt;
  logic [GUARD_W-1:0] r_guard_cnt;

  logic               w_start_press;
  logic               w_pause_press;
  logic [2:0]         w_next;
  logic [LEVEL_W-1:0] w_level_next;
  logic [END_W-1:0]   w_end_next;
  logic [GUARD_W-1:0] w_guard_next;
  logic [1:0]         w_screen_next;

  // Rising-edge detect; the edge registers clear in reset, so a button held
  // through reset registers as a press on the first cycle afterwards.
  assign w_start_press = btn_start & ~r_start_q;
  assign w_pause_press = btn_pause & ~r_pause_q;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    w_next       = r_state;
    w_level_next = level;
    w_end_next   = r_end_cnt;
    w_guard_next = r_guard_cnt;
    case (r_state)
      S_TITLE: if (w_start_press) w_next = S_START;
      S_START: begin
        w_next       = S_PLAY;
        w_guard_next = GUARD_LOAD;
      end
      S_PLAY: begin
        if (r_guard_cnt != '0) begin
          w_guard_next = r_guard_cnt - 1'b1;
        end else if (game_lost) begin
          w_next     = S_LOST;
          w_end_next = END_LOAD;
        end else if (game_won) begin
          w_next       = S_WON;
          w_end_next   = END_LOAD;
          w_level_next = (level < LEVEL_MAX) ? level + 1'b1 : LEVEL_MAX;
        end else if (w_pause_press) begin
          w_next = S_PAUSE;
        end
      end
      S_PAUSE: if (w_pause_press || w_start_press) w_next = S_PLAY;
      S_WON: begin
        if (r_end_cnt == '0 || w_start_press) w_next = S_START;
        else                                  w_end_next = r_end_cnt - 1'b1;
      end
      S_LOST: begin
        if (r_end_cnt == '0 || w_start_press) begin
          w_next       = S_TITLE;
          w_level_next = LEVEL_MIN;
        end else begin
          w_end_next = r_end_cnt - 1'b1;
        end
      end
      default: w_next = S_TITLE;
    endcase
  end

  always_comb begin
    w_screen_next = 2'd0;
    case (w_next)
      S_START, S_PLAY, S_PAUSE: w_screen_next = 2'd1;
      S_WON:                    w_screen_next = 2'd2;
      S_LOST:                   w_screen_next = 2'd3;
      default:                  w_screen_next = 2'd0;
    endcase
  end

  // Outputs are decoded from the next state so they are valid in the same
  // cycle the state is entered.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      r_state     <= S_TITLE;
      r_start_q   <= 1'b0;
      r_pause_q   <= 1'b0;
      r_end_cnt   <= '0;
      r_guard_cnt <= '0;
      round_rst   <= 1'b1;
      game_active <= 1'b0;
      paused      <= 1'b0;
      screen      <= 2'd0;
      level       <= LEVEL_MIN;
    end else begin
      r_state     <= w_next;
      r_start_q   <= btn_start;
      r_pause_q   <= btn_pause;
      r_end_cnt   <= w_end_next;
      r_guard_cnt <= w_guard_next;
      round_rst   <= (w_next == S_START);
      game_active <= (w_next == S_PLAY);
      paused      <= (w_next == S_PAUSE);
      screen      <= w_screen_next;
      level       <= w_level_next;
    end
  end

endmodule
